// File: rtl/action_pkg.sv
// Shared definitions for the sprite lanes and the action event queue:
// default message-type width, message-type encodings and the packing
// helper that forms {type, pitch} words.
package action_pkg;

  localparam int MSG_TYPE_W = 3;

  // Widest {type, pitch} word the packing helper can form.
  localparam int MAX_MSG_W  = 32;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_NONE    = 3'd0,
    MSG_PRESS   = 3'd1,
    MSG_HOLD    = 3'd2,
    MSG_RELEASE = 3'd3,
    MSG_HIT     = 3'd4,
    MSG_MISS    = 3'd5,
    MSG_PERFECT = 3'd6,
    MSG_SPECIAL = 3'd7
  } msg_type_e;

  // Packs a message type above a pitch field of pitch_w bits.
  function automatic logic [MAX_MSG_W-1:0] pack_msg(
    input logic [MAX_MSG_W-1:0] msg_type,
    input logic [MAX_MSG_W-1:0] pitch,
    input int                   pitch_w
  );
    pack_msg = (msg_type << pitch_w) | pitch;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on o_head
// whenever the FIFO is not empty. Push and pop in the same cycle are
// legal, including when full.
module msg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == LVL_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset so the head word reads as zero when empty; drop this for large RAM-based FIFOs.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/action_event_queue.sv
// Latches per-key action messages from the sprite lanes, serialises them
// with a round-robin arbiter into a show-ahead FIFO and presents them as
// {type, pitch} words on a valid/ready interface. Overwritten pending
// events are counted in a saturating collision counter.
module action_event_queue
  import action_pkg::*;
#(
  parameter int NUM_KEYS   = 61,
  parameter int MSG_TYPE_W = action_pkg::MSG_TYPE_W,
  parameter int DEPTH      = 8,
  parameter int DROP_W     = 8,
  localparam int PITCH_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int MSG_W     = MSG_TYPE_W + PITCH_W,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_KEYS-1:0]            req,
  input  logic [NUM_KEYS*MSG_TYPE_W-1:0] req_type,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MSG_W-1:0]               out_msg,
  output logic [LVL_W-1:0]               fifo_level,
  output logic [NUM_KEYS-1:0]            pending,
  output logic [DROP_W-1:0]              drop_count
);

  localparam int CNT_W = $clog2(NUM_KEYS + 1);
  localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  logic [NUM_KEYS-1:0]   r_pending;
  logic [MSG_TYPE_W-1:0] r_ptype [NUM_KEYS];
  logic [PITCH_W-1:0]    r_last_grant;
  logic [DROP_W-1:0]     r_drop_count;

  logic                  w_lo_found;
  logic [PITCH_W-1:0]    w_lo_idx;
  logic                  w_hi_found;
  logic [PITCH_W-1:0]    w_hi_idx;
  logic                  w_grant_valid;
  logic [PITCH_W-1:0]    w_grant_idx;
  logic [NUM_KEYS-1:0]   w_grant_onehot;
  logic [NUM_KEYS-1:0]   w_collide;
  logic [CNT_W-1:0]      w_collide_cnt;
  logic [SUM_W-1:0]      w_drop_sum;
  logic [DROP_W-1:0]     w_drop_next;
  logic [MSG_W-1:0]      w_push_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // Round-robin search: lowest pending lane above last_grant, else lowest overall.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    // Descending scan: the last hit is the lowest index in each class.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PITCH_W'(i);
        if (PITCH_W'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PITCH_W'(i);
        end
      end
    end
  end

  // A full FIFO blocks the grant; a same-cycle pop only helps next cycle.
  assign w_grant_valid = w_lo_found && !w_fifo_full;
  assign w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

  // The granted lane's type is read before this edge's request reloads it.
  assign w_push_data = MSG_W'(pack_msg(MAX_MSG_W'(r_ptype[w_grant_idx]),
                                       MAX_MSG_W'(w_grant_idx), PITCH_W));

  // Grant decode and collision detection per lane.
  always_comb begin
    w_grant_onehot = '0;
    w_collide      = '0;
    w_collide_cnt  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_grant_onehot[i] = w_grant_valid && (w_grant_idx == PITCH_W'(i));
      w_collide[i]      = req[i] && r_pending[i] && !w_grant_onehot[i];
      w_collide_cnt     = w_collide_cnt + CNT_W'(w_collide[i]);
    end
  end

  // Saturating add of this cycle's collisions.
  always_comb begin
    w_drop_sum  = SUM_W'(r_drop_count) + SUM_W'(w_collide_cnt);
    w_drop_next = (w_drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : DROP_W'(w_drop_sum);
  end

  // Pending flags and latched types: a new request always wins over a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_ptype[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (req[i]) begin
          r_pending[i] <= 1'b1;
          r_ptype[i]   <= req_type[i*MSG_TYPE_W +: MSG_TYPE_W];
        end else if (w_grant_onehot[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer and collision counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= PITCH_W'(NUM_KEYS - 1);
      r_drop_count <= '0;
    end else begin
      if (w_grant_valid) r_last_grant <= w_grant_idx;
      r_drop_count <= w_drop_next;
    end
  end

  msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_grant_valid),
    .i_push_data (w_push_data),
    .i_pop       (out_ready),
    .o_head      (out_msg),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (fifo_level)
  );

  assign out_valid  = !w_fifo_empty;
  assign pending    = r_pending;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_action_event_queue.sv
// Scoreboard bench for action_event_queue: expected {type, pitch} words
// are queued as stimulus is driven and compared as the DUT hands them out.
module tb_action_event_queue;

  localparam int NK = 61;
  localparam int TW = 3;
  localparam int PW = 6;
  localparam int MW = TW + PW;

  logic               clk;
  logic               reset_n;
  logic [NK-1:0]      req;
  logic [NK*TW-1:0]   req_type;
  logic               out_valid;
  logic               out_ready;
  logic [MW-1:0]      out_msg;
  logic [3:0]         fifo_level;
  logic [NK-1:0]      pending;
  logic [7:0]         drop_count;

  int n_total;
  int n_bad;

  logic [MW-1:0] exp_q [$];
  logic [MW-1:0] mon_exp;

  action_event_queue #(
    .NUM_KEYS   (NK),
    .MSG_TYPE_W (TW),
    .DEPTH      (8),
    .DROP_W     (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_type   (req_type),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_msg    (out_msg),
    .fifo_level (fifo_level),
    .pending    (pending),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] msg(input int t, input int lane);
    logic [MW-1:0] m;
    m[PW-1:0]  = lane[PW-1:0];
    m[MW-1:PW] = t[TW-1:0];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int lane, input int t);
    req[lane] = 1'b1;
    req_type[lane*TW +: TW] = t[TW-1:0];
  endtask

  task automatic clr_req();
    req = '0;
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_level(input int lvl, input string tag);
    int k = 0;
    while (k < 50 && int'(fifo_level) != lvl) begin
      tick();
      k++;
    end
    check({tag, "_level_reached"}, 64'(fifo_level), 64'(lvl));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (k < 200 && !(exp_q.size() == 0 && !out_valid)) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  // Output monitor: compares each accepted word with the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'(out_msg), {64{1'b1}});
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_msg", 64'(out_msg), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    req       = '0;
    req_type  = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid",   64'(out_valid),  64'd0);
    check("rst_msg",     64'(out_msg),    64'd0);
    check("rst_level",   64'(fifo_level), 64'd0);
    check("rst_pending", 64'(pending),    64'd0);
    check("rst_drop",    64'(drop_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single event on lane 12: out_valid two cycles after the request
    set_req(12, 2);
    tick();
    clr_req();
    check("single_pending", 64'(pending[12]), 64'd1);
    check("single_valid_t1", 64'(out_valid), 64'd0);
    tick();
    check("single_valid_t2", 64'(out_valid), 64'd1);
    check("single_msg", 64'(out_msg), 64'(msg(2, 12)));
    exp_q.push_back(msg(2, 12));
    out_ready = 1'b1;
    tick();
    check("single_after_pop", 64'(out_valid), 64'd0);

    // Fairness from a fresh pointer, then wrap after lane 60
    do_reset();
    exp_q.push_back(msg(1, 0));
    exp_q.push_back(msg(2, 30));
    exp_q.push_back(msg(3, 60));
    set_req(60, 3);
    set_req(0, 1);
    set_req(30, 2);
    tick();
    clr_req();
    drain("fair1");
    exp_q.push_back(msg(4, 0));
    exp_q.push_back(msg(5, 60));
    set_req(0, 4);
    set_req(60, 5);
    tick();
    clr_req();
    drain("fair2");

    // Back-pressure: 10 lanes into an 8-deep FIFO
    out_ready = 1'b0;
    for (int lane = 1; lane <= 10; lane++) begin
      exp_q.push_back(msg(lane % 8, lane));
      set_req(lane, lane % 8);
    end
    tick();
    clr_req();
    wait_level(8, "bp");
    repeat (3) tick();
    check("bp_level", 64'(fifo_level), 64'd8);
    check("bp_pending", 64'(pending), (64'd1 << 9) | (64'd1 << 10));
    check("bp_pending_cnt", 64'($countones(pending)), 64'd2);
    out_ready = 1'b1;
    drain("bp");
    check("bp_drop", 64'(drop_count), 64'd0);

    // Single collision on lane 5 while the FIFO is full
    out_ready = 1'b0;
    for (int lane = 20; lane <= 27; lane++) begin
      exp_q.push_back(msg(lane % 8, lane));
      set_req(lane, lane % 8);
    end
    tick();
    clr_req();
    wait_level(8, "col1");
    set_req(5, 1);
    tick();
    clr_req();
    check("col1_pending", 64'(pending[5]), 64'd1);
    check("col1_drop0", 64'(drop_count), 64'd0);
    set_req(5, 4);
    tick();
    clr_req();
    check("col1_drop1", 64'(drop_count), 64'd1);
    exp_q.push_back(msg(4, 5));
    out_ready = 1'b1;
    drain("col1");
    check("col1_drop_kept", 64'(drop_count), 64'd1);

    // 300 collisions saturate the counter
    out_ready = 1'b0;
    for (int lane = 30; lane <= 37; lane++) begin
      exp_q.push_back(msg(lane % 8, lane));
      set_req(lane, lane % 8);
    end
    tick();
    clr_req();
    wait_level(8, "col2");
    set_req(5, 0);
    tick();
    for (int i = 0; i < 300; i++) begin
      set_req(5, i % 8);
      tick();
    end
    clr_req();
    check("col2_drop_sat", 64'(drop_count), 64'd255);
    exp_q.push_back(msg(299 % 8, 5));
    out_ready = 1'b1;
    drain("col2");
    check("col2_drop_hold", 64'(drop_count), 64'd255);

    // Same-cycle grant and new request on lane 7
    do_reset();
    check("sc_drop_start", 64'(drop_count), 64'd0);
    exp_q.push_back(msg(3, 7));
    exp_q.push_back(msg(6, 7));
    set_req(7, 3);
    tick();
    check("sc_pending", 64'(pending[7]), 64'd1);
    set_req(7, 6);
    tick();
    clr_req();
    check("sc_repending", 64'(pending[7]), 64'd1);
    check("sc_level", 64'(fifo_level), 64'd1);
    drain("sc");
    check("sc_drop", 64'(drop_count), 64'd0);

    // Reset mid-burst with 5 entries queued
    out_ready = 1'b0;
    for (int lane = 40; lane <= 46; lane++) set_req(lane, lane % 8);
    tick();
    clr_req();
    wait_level(5, "mid");
    check("mid_pending_busy", 64'($countones(pending)), 64'd2);
    reset_n = 1'b0;
    #1;
    check("mid_valid",   64'(out_valid),  64'd0);
    check("mid_msg",     64'(out_msg),    64'd0);
    check("mid_level",   64'(fifo_level), 64'd0);
    check("mid_pending", 64'(pending),    64'd0);
    check("mid_drop",    64'(drop_count), 64'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("mid_post_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
